// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 16x16 register file: sequences operand reads and writebacks.
// Optional REGCTL_R0_ZERO_EN hardwires register 0 to zero.
module regfile_access_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_aa,
   input  logic [ADDR_WIDTH-1:0] req_ba,
   input  logic [ADDR_WIDTH-1:0] req_da,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_a,
   output logic [DATA_WIDTH-1:0] rsp_b,
   output logic [DATA_WIDTH-1:0] rsp_d,
   output logic                  wr_done,
   output logic                  rf_reset,
   output logic                  rf_rw,
   output logic [ADDR_WIDTH-1:0] rf_aa,
   output logic [ADDR_WIDTH-1:0] rf_ba,
   output logic [ADDR_WIDTH-1:0] rf_da,
   output logic [DATA_WIDTH-1:0] rf_result,
   input  logic [DATA_WIDTH-1:0] rf_aout,
   input  logic [DATA_WIDTH-1:0] rf_bout,
   input  logic [DATA_WIDTH-1:0] rf_dout
);

   localparam logic [2:0] StInit = 3'd0;
   localparam logic [2:0] StIdle = 3'd1;
   localparam logic [2:0] StRd   = 3'd2;
   localparam logic [2:0] StCap  = 3'd3;
   localparam logic [2:0] StResp = 3'd4;
   localparam logic [2:0] StWr   = 3'd5;

`ifdef REGCTL_R0_ZERO_EN
   localparam bit R0Zero = 1'b1;
`else
   localparam bit R0Zero = 1'b0;
`endif

   logic [2:0]            state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d;
   logic [DATA_WIDTH-1:0] rsp_b_q, rsp_b_d;
   logic [DATA_WIDTH-1:0] rsp_d_q, rsp_d_d;
   logic                  wr_done_q, wr_done_d;
   logic                  rf_reset_q, rf_reset_d;
   logic                  rf_rw_q, rf_rw_d;
   logic [ADDR_WIDTH-1:0] rf_aa_q, rf_aa_d;
   logic [ADDR_WIDTH-1:0] rf_ba_q, rf_ba_d;
   logic [ADDR_WIDTH-1:0] rf_da_q, rf_da_d;
   logic [DATA_WIDTH-1:0] rf_result_q, rf_result_d;

   logic accept;
   logic r0_skip;

   assign accept  = (state_q == StIdle) && req_valid && req_ready_q;
   assign r0_skip = R0Zero && (req_da == '0);

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_a_d     = rsp_a_q;
      rsp_b_d     = rsp_b_q;
      rsp_d_d     = rsp_d_q;
      wr_done_d   = 1'b0;
      rf_reset_d  = 1'b0;
      rf_rw_d     = 1'b0;
      rf_aa_d     = rf_aa_q;
      rf_ba_d     = rf_ba_q;
      rf_da_d     = rf_da_q;
      rf_result_d = rf_result_q;

      case (state_q)
         StInit: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
         StIdle: begin
            req_ready_d = 1'b1;
            if (accept) begin
               req_ready_d = 1'b0;
               rf_aa_d     = req_aa;
               rf_ba_d     = req_ba;
               rf_da_d     = req_da;
               rf_result_d = req_data;
               if (!req_write) begin
                  state_d = StRd;
               end else if (r0_skip) begin
                  // Write to hardwired r0: nothing to commit, acknowledge straight away.
                  state_d   = StIdle;
                  wr_done_d = 1'b1;
               end else begin
                  state_d = StWr;
                  rf_rw_d = 1'b1;
               end
            end
         end
         StRd: begin
            state_d = StCap;
         end
         StCap: begin
            rsp_a_d     = (R0Zero && (rf_aa_q == '0)) ? '0 : rf_aout;
            rsp_b_d     = (R0Zero && (rf_ba_q == '0)) ? '0 : rf_bout;
            rsp_d_d     = (R0Zero && (rf_da_q == '0)) ? '0 : rf_dout;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         StWr: begin
            wr_done_d   = 1'b1;
            req_ready_d = 1'b1;
            state_d     = StIdle;
         end
         default: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StInit;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_a_q     <= '0;
         rsp_b_q     <= '0;
         rsp_d_q     <= '0;
         wr_done_q   <= 1'b0;
         rf_reset_q  <= 1'b1;
         rf_rw_q     <= 1'b0;
         rf_aa_q     <= '0;
         rf_ba_q     <= '0;
         rf_da_q     <= '0;
         rf_result_q <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_a_q     <= rsp_a_d;
         rsp_b_q     <= rsp_b_d;
         rsp_d_q     <= rsp_d_d;
         wr_done_q   <= wr_done_d;
         rf_reset_q  <= rf_reset_d;
         rf_rw_q     <= rf_rw_d;
         rf_aa_q     <= rf_aa_d;
         rf_ba_q     <= rf_ba_d;
         rf_da_q     <= rf_da_d;
         rf_result_q <= rf_result_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_a     = rsp_a_q;
   assign rsp_b     = rsp_b_q;
   assign rsp_d     = rsp_d_q;
   assign wr_done   = wr_done_q;
   assign rf_reset  = rf_reset_q;
   assign rf_rw     = rf_rw_q;
   assign rf_aa     = rf_aa_q;
   assign rf_ba     = rf_ba_q;
   assign rf_da     = rf_da_q;
   assign rf_result = rf_result_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file, read scoreboard, directed writes.
module tb_regfile_access_ctrl;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 16;

`ifdef REGCTL_R0_ZERO_EN
   localparam bit R0 = 1'b1;
`else
   localparam bit R0 = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_aa = '0, req_ba = '0, req_da = '0;
   logic [DW-1:0] req_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_a, rsp_b, rsp_d;
   logic          wr_done, rf_reset, rf_rw;
   logic [AW-1:0] rf_aa, rf_ba, rf_da;
   logic [DW-1:0] rf_result;
   logic [DW-1:0] rf_aout = '0, rf_bout = '0, rf_dout = '0;

   regfile_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_aa(req_aa), .req_ba(req_ba), .req_da(req_da), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_d(rsp_d), .wr_done(wr_done),
      .rf_reset(rf_reset), .rf_rw(rf_rw),
      .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_da(rf_da), .rf_result(rf_result),
      .rf_aout(rf_aout), .rf_bout(rf_bout), .rf_dout(rf_dout)
   );

   always #5 clk = ~clk;

   // Register file: synchronous init to index values, registered read ports.
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      rf_aout <= mem[rf_aa];
      rf_bout <= mem[rf_ba];
      rf_dout <= mem[rf_da];
      if (rf_reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= DW'(i);
      end else if (rf_rw) begin
         mem[rf_da] <= rf_result;
      end
   end

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] d;
   } rsp_t;
   rsp_t exp_q[$];

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_acc = 0;
   int wr_pulses = 0;
   int exp_wr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (reset && wr_done) wr_pulses++;

   // Monitor: one comparison per response handshake.
   always @(negedge clk) begin
      if (reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_a", 32'(rsp_a), 32'(e.a));
            chk("rsp_b", 32'(rsp_b), 32'(e.b));
            chk("rsp_d", 32'(rsp_d), 32'(e.d));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                        input logic [AW-1:0] da, input logic [DW-1:0] data);
      req_write = wr;
      req_aa    = aa;
      req_ba    = ba;
      req_da    = da;
      req_data  = data;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      last_acc  = cyc;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("rsp_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ba, input logic [AW-1:0] da,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [DW-1:0] ed);
      rsp_t e;
      wait_ready();
      e.a = ea;
      e.b = eb;
      e.d = ed;
      exp_q.push_back(e);
      issue(1'b0, aa, ba, da, '0);
      chk("rd_lat_rd", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("rd_lat_cap", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("rd_lat_resp", 32'(rsp_valid), 32'd1);
      drain();
   endtask

   task automatic wr(input logic [AW-1:0] da, input logic [DW-1:0] data, input logic skip);
      wait_ready();
      issue(1'b1, '0, '0, da, data);
      if (!skip) begin
         chk("wr_rf_rw", 32'(rf_rw), 32'd1);
         chk("wr_rf_da", 32'(rf_da), 32'(da));
         chk("wr_rf_result", 32'(rf_result), 32'(data));
         chk("wr_done_early", 32'(wr_done), 32'd0);
         @(posedge clk);
         #1;
         chk("wr_idle_ready", 32'(req_ready), 32'd1);
      end
      chk("wr_rf_rw_low", 32'(rf_rw), 32'd0);
      chk("wr_done", 32'(wr_done), 32'd1);
      exp_wr++;
   endtask

   initial begin
      int c1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rf_reset", 32'(rf_reset), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rf_rw", 32'(rf_rw), 32'd0);
      chk("rst_wr_done", 32'(wr_done), 32'd0);
      chk("rst_rf_da", 32'(rf_da), 32'd0);
      chk("rst_rsp_a", 32'(rsp_a), 32'd0);
      reset = 1'b1;
      #1;
      chk("init_rf_reset", 32'(rf_reset), 32'd1);
      @(negedge clk);
      chk("init_rf_reset_drop", 32'(rf_reset), 32'd0);
      chk("init_req_ready", 32'(req_ready), 32'd1);

      rd(4'd3, 4'd7, 4'd15, 16'd3, 16'd7, 16'd15);

      wr(4'd5, 16'hBEEF, 1'b0);
      rd(4'd5, 4'd4, 4'd6, 16'hBEEF, 16'd4, 16'd6);

      // Stalled response must hold stable.
      rsp_ready = 1'b0;
      wait_ready();
      exp_q.push_back('{a: 16'd2, b: 16'd2, d: 16'd2});
      issue(1'b0, 4'd2, 4'd2, 4'd2, '0);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_a", 32'(rsp_a), 32'd2);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain();
      chk("stall_post_ready", 32'(req_ready), 32'd1);
      chk("stall_post_valid", 32'(rsp_valid), 32'd0);

      // Reset during WR: write is dropped, registers re-initialise.
      wait_ready();
      issue(1'b1, '0, '0, 4'd9, 16'h1234);
      reset = 1'b0;
      #1;
      chk("rstwr_rf_rw", 32'(rf_rw), 32'd0);
      chk("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstwr_rf_reset", 32'(rf_reset), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      rd(4'd9, 4'd5, 4'd1, 16'd9, 16'd5, 16'd1);

      // Reset while a response is held: rsp_valid drops at once.
      rsp_ready = 1'b0;
      wait_ready();
      exp_q.push_back('{a: 16'd4, b: 16'd4, d: 16'd4});
      issue(1'b0, 4'd4, 4'd4, 4'd4, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rstrsp_before", 32'(rsp_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("rstrsp_valid", 32'(rsp_valid), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;

      // Back-to-back writes every 2 cycles.
      wr(4'd1, 16'h1111, 1'b0);
      c1 = last_acc;
      wr(4'd2, 16'h2222, 1'b0);
      chk("btb_gap12", 32'(last_acc - c1), 32'd2);
      c1 = last_acc;
      wr(4'd3, 16'h3333, 1'b0);
      chk("btb_gap23", 32'(last_acc - c1), 32'd2);
      rd(4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h3333);

      // Register 0 behaviour depends on the build option.
      wr(4'd0, 16'hFFFF, R0);
      rd(4'd0, 4'd0, 4'd0, R0 ? 16'h0 : 16'hFFFF, R0 ? 16'h0 : 16'hFFFF,
         R0 ? 16'h0 : 16'hFFFF);
      rd(4'd0, 4'd1, 4'd2, R0 ? 16'h0 : 16'hFFFF, 16'h1111, 16'h2222);

      repeat (2) @(negedge clk);
      chk("wr_done_count", 32'(wr_pulses), 32'(exp_wr));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
